log_afpm_stream: RTL and testbench

//  Parametrised byte-serial floating-point multiplier; successor to the fixed FP16 log multiplier.

---
 rtl/log_afpm_stream_if.sv | 24 ++
 rtl/log_afpm_stream.sv | 169 ++++++++++++++++
 tb/tb_log_afpm_stream.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/log_afpm_stream_if.sv
// Byte-serial handshake bundle for log_afpm_stream: operand input stream, result output stream, status.
interface log_afpm_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [2:0] out_flags;
    logic       busy;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_flags, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last, out_flags, busy
    );
endinterface

// File: rtl/log_afpm_stream.sv
// Byte-serial floating-point multiplier: Mitchell log-domain approximation (mode 0)
// or exact iterative shift-add mantissa product (mode 1), with special-value handling.
module log_afpm_stream #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input logic              clk,
    input logic              rst_n,
    log_afpm_stream_if.slave bus
);
    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int NB      = W / 8;
    localparam int CNT_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int IT_W    = $clog2(MAN_W + 1);
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
    localparam logic [IT_W-1:0]  LAST_ITER = IT_W'(MAN_W);

    typedef enum logic [2:0] {
        IDLE, COLLECT, CLASSIFY, COMPUTE, PACK, OUTPUT
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, b_q, result_q;
    logic             mode_q, ce_q, special_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IT_W-1:0]  iter_q;
    logic [MAN_W+1:0] acc_q;
    logic [MAN_W:0]   mb_q;
    logic [MAN_W-1:0] mout_q;
    logic [2:0]       flags_q;

    logic             sign_a, sign_b, sign_r;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic             zero_a, zero_b, inf_a, inf_b;
    logic             in_fire, out_fire;
    logic [MAN_W+1:0] mul_sum;
    logic [MAN_W:0]   mitch_sum;
    int               exp_t;
    logic [W-1:0]     pack_res;
    logic [2:0]       pack_flags;

    assign sign_a = a_q[W-1];
    assign sign_b = b_q[W-1];
    assign sign_r = sign_a ^ sign_b;
    assign exp_a  = a_q[W-2 -: EXP_W];
    assign exp_b  = b_q[W-2 -: EXP_W];
    assign man_a  = a_q[MAN_W-1:0];
    assign man_b  = b_q[MAN_W-1:0];
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = &exp_a;
    assign inf_b  = &exp_b;

    assign in_fire  = bus.in_valid && (state_q == COLLECT);
    assign out_fire = bus.out_ready && (state_q == OUTPUT);

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == OUTPUT);
    assign bus.out_data  = (state_q == OUTPUT) ? result_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    assign bus.out_last  = (state_q == OUTPUT) && (cnt_q == LAST_BEAT);
    assign bus.out_flags = (state_q == OUTPUT) ? flags_q : 3'b000;
    assign bus.busy      = (state_q != IDLE) && (state_q != COLLECT);

    // Right-shifting accumulator: bits shifted out never feed back, so the kept
    // upper bits equal P[2*MAN_W+1:MAN_W] after the final (unshifted) step.
    assign mul_sum   = acc_q + (mb_q[0] ? {2'b01, man_a} : '0);
    assign mitch_sum = {1'b0, man_a} + {1'b0, man_b};

    always_comb begin
        exp_t      = int'(exp_a) + int'(exp_b) + int'(ce_q) - BIAS;
        pack_res   = {sign_r, exp_t[EXP_W-1:0], mout_q};
        pack_flags = 3'b000;
        if (exp_t >= EXP_MAX) begin
            pack_res   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags = 3'b010;
        end else if (exp_t <= 0) begin
            pack_res   = {sign_r, {(W-1){1'b0}}};
            pack_flags = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = COLLECT;
            COLLECT:  if (in_fire && cnt_q == LAST_BEAT) state_d = CLASSIFY;
            CLASSIFY: state_d = (zero_a || zero_b || inf_a || inf_b) ? PACK : COMPUTE;
            COMPUTE:  if (!mode_q || iter_q == LAST_ITER) state_d = PACK;
            PACK:     state_d = OUTPUT;
            OUTPUT:   if (out_fire && cnt_q == LAST_BEAT) state_d = COLLECT;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            mode_q    <= 1'b0;
            ce_q      <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
            iter_q    <= '0;
            acc_q     <= '0;
            mb_q      <= '0;
            mout_q    <= '0;
            flags_q   <= 3'b000;
        end else begin
            case (state_q)
                COLLECT: if (in_fire) begin
                    a_q[{cnt_q, 3'b000} +: 8] <= bus.in_a;
                    b_q[{cnt_q, 3'b000} +: 8] <= bus.in_b;
                    if (cnt_q == '0) mode_q <= bus.in_mode;
                    cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
                end
                CLASSIFY: begin
                    special_q <= zero_a || zero_b || inf_a || inf_b;
                    acc_q     <= '0;
                    mb_q      <= {1'b1, man_b};
                    iter_q    <= '0;
                    flags_q   <= 3'b000;
                    if ((zero_a && inf_b) || (inf_a && zero_b)) begin
                        result_q <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                        flags_q  <= 3'b100;
                    end else if (inf_a || inf_b) begin
                        result_q <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (zero_a || zero_b) begin
                        result_q <= {sign_r, {(W-1){1'b0}}};
                    end
                end
                COMPUTE: begin
                    if (!mode_q) begin
                        {ce_q, mout_q} <= mitch_sum;
                    end else if (iter_q == LAST_ITER) begin
                        ce_q   <= mul_sum[MAN_W+1];
                        mout_q <= mul_sum[MAN_W+1] ? mul_sum[MAN_W:1] : mul_sum[MAN_W-1:0];
                        iter_q <= '0;
                    end else begin
                        acc_q  <= {1'b0, mul_sum[MAN_W+1:1]};
                        mb_q   <= mb_q >> 1;
                        iter_q <= iter_q + 1'b1;
                    end
                end
                PACK: if (!special_q) begin
                    result_q <= pack_res;
                    flags_q  <= pack_flags;
                end
                OUTPUT: if (out_fire) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_q   <= '0;
                        flags_q <= 3'b000;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_log_afpm_stream.sv
// Directed self-checking bench for log_afpm_stream with FP16 parameters.
module tb_log_afpm_stream;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    log_afpm_stream_if bus();

    log_afpm_stream #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic m);
        int guard = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_ready_wait: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_operands(input logic [15:0] a, input logic [15:0] b, input logic m, input int gap);
        for (int k = 0; k < 2; k++) begin
            drive_beat(a[8*k +: 8], b[8*k +: 8], m);
            if (k == 0 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic read_result(output logic [15:0] res, output logic [2:0] flg, output logic [1:0] lastv);
        bus.out_ready = 1'b1;
        res[7:0] = bus.out_data;
        flg      = bus.out_flags;
        lastv[0] = bus.out_last;
        @(posedge clk);
        #1;
        res[15:8] = bus.out_data;
        lastv[1]  = bus.out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_flags, bus.busy} !== 15'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b data=%h last=%b flags=%b busy=%b required all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_flags, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_to_collect: got rdy=%b busy=%b required rdy=1 busy=0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_mode0;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        send_operands(16'h3E00, 16'h3E00, 1'b0, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if (lat != 3) begin errors++; $display("[TB] FAIL m0_latency: got %0d required 3", lat); end
        checks++;
        if (res !== 16'h4000) begin errors++; $display("[TB] FAIL m0_result: got %h required 4000", res); end
        checks++;
        if (flg !== 3'b000) begin errors++; $display("[TB] FAIL m0_flags: got %b required 000", flg); end
        checks++;
        if (lastv !== 2'b10) begin errors++; $display("[TB] FAIL m0_last: got %b required 10", lastv); end
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_flags} !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL back_to_back: got vld=%b rdy=%b flags=%b required vld=0 rdy=1 flags=000",
                     bus.out_valid, bus.in_ready, bus.out_flags);
        end
    endtask

    task automatic test_mode1;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        send_operands(16'h3E00, 16'h3E00, 1'b1, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if (lat != 13) begin errors++; $display("[TB] FAIL m1_latency: got %0d required 13", lat); end
        checks++;
        if (res !== 16'h4080) begin errors++; $display("[TB] FAIL m1_result: got %h required 4080", res); end
    endtask

    task automatic test_both_modes;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        for (int m = 0; m < 2; m++) begin
            send_operands(16'h4000, 16'h4200, m[0], 0);
            wait_result(lat);
            read_result(res, flg, lastv);
            checks++;
            if (res !== 16'h4600) begin errors++; $display("[TB] FAIL both_modes_m%0d: got %h required 4600", m, res); end
        end
    endtask

    task automatic test_sign;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        send_operands(16'hC000, 16'h4000, 1'b0, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if (res !== 16'hC400) begin errors++; $display("[TB] FAIL sign: got %h required C400", res); end
    endtask

    task automatic test_range;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        send_operands(16'h7BFF, 16'h7BFF, 1'b0, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if ({res, flg} !== {16'h7C00, 3'b010}) begin
            errors++; $display("[TB] FAIL overflow: got %h/%b required 7C00/010", res, flg);
        end
        send_operands(16'h0400, 16'h0400, 1'b1, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if ({res, flg} !== {16'h0000, 3'b001}) begin
            errors++; $display("[TB] FAIL underflow: got %h/%b required 0000/001", res, flg);
        end
    endtask

    task automatic test_specials;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        send_operands(16'h0000, 16'h7C00, 1'b1, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if (lat != 2) begin errors++; $display("[TB] FAIL nan_latency: got %0d required 2", lat); end
        checks++;
        if ({res, flg} !== {16'h7E00, 3'b100}) begin
            errors++; $display("[TB] FAIL nan: got %h/%b required 7E00/100", res, flg);
        end
        send_operands(16'h7C00, 16'hC000, 1'b0, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if ({res, flg} !== {16'hFC00, 3'b000}) begin
            errors++; $display("[TB] FAIL inf: got %h/%b required FC00/000", res, flg);
        end
        send_operands(16'h8000, 16'h4000, 1'b0, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if ({res, flg, lat[7:0]} !== {16'h8000, 3'b000, 8'd2}) begin
            errors++; $display("[TB] FAIL zero: got %h/%b lat %0d required 8000/000 lat 2", res, flg, lat);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        logic [7:0] d0; int unstable = 0;
        bus.out_ready = 1'b0;
        send_operands(16'h4000, 16'h4200, 1'b1, 0);
        wait_result(lat);
        d0 = bus.out_data;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.out_data !== d0 || bus.out_last !== 1'b0 || bus.out_valid !== 1'b1) unstable++;
        end
        checks++;
        if (unstable != 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d unstable cycles required 0", unstable); end
        read_result(res, flg, lastv);
        checks++;
        if ({res, lastv} !== {16'h4600, 2'b10}) begin
            errors++; $display("[TB] FAIL stall_result: got %h last %b required 4600 last 10", res, lastv);
        end
    endtask

    task automatic test_gaps;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        send_operands(16'h3E00, 16'h3E00, 1'b0, 4);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if (res !== 16'h4000) begin errors++; $display("[TB] FAIL gaps: got %h required 4000", res); end
    endtask

    task automatic test_reset_midop;
        logic [15:0] res; logic [2:0] flg; logic [1:0] lastv; int lat;
        send_operands(16'h3E00, 16'h3E00, 1'b1, 0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midop_busy: got %b required 1", bus.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_flags, bus.busy} !== 15'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got rdy=%b vld=%b data=%h last=%b flags=%b busy=%b required all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_flags, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_operands(16'h4000, 16'h4200, 1'b0, 0);
        wait_result(lat);
        read_result(res, flg, lastv);
        checks++;
        if ({res, lat[7:0]} !== {16'h4600, 8'd3}) begin
            errors++; $display("[TB] FAIL after_reset: got %h lat %0d required 4600 lat 3", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_both_modes();
        test_sign();
        test_range();
        test_specials();
        test_backpressure();
        test_gaps();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
